// File: rtl/featuremap_pkg.sv
// Shared types and helpers for the feature-map pad writer.
// Border insertion is enabled by defining FEATUREMAP_PAD_BORDER_EN.
package featuremap_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int PAD = 1;

`ifdef FEATUREMAP_PAD_BORDER_EN
  localparam bit BORDER_EN = 1'b1;
`else
  localparam bit BORDER_EN = 1'b0;
`endif

  function automatic int pad_dim(input int d);
    return BORDER_EN ? d + 2 * PAD : d;
  endfunction

endpackage

// File: rtl/featuremap_pad_writer_if.sv
// Pixel-in / FIFO-write handshake bundle of the pad writer.
// master = stream source + FIFO side, slave = pad writer.
interface featuremap_pad_writer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  ready_out;
  logic                  fifo_full;
  logic                  wrreq;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    output valid_in,
    output data_in,
    output fifo_full,
    input  ready_out,
    input  wrreq,
    input  data_out
  );

  modport slave (
    input  valid_in,
    input  data_in,
    input  fifo_full,
    output ready_out,
    output wrreq,
    output data_out
  );
endinterface

// File: rtl/pad_raster_counter.sv
// Raster row/col position over the (optionally padded) frame.
// Flags border positions and the final position of the frame.
module pad_raster_counter
  import featuremap_pkg::*;
#(
  parameter int WIDTH  = 56,
  parameter int HEIGHT = 56
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic adv,
  output logic border,
  output logic last
);
  localparam int PW = pad_dim(WIDTH);
  localparam int PH = pad_dim(HEIGHT);
  localparam int CW = $clog2(WIDTH + 2);
  localparam int RW = $clog2(HEIGHT + 2);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_last;
  logic          row_last;

  assign col_last = (col == CW'(PW - 1));
  assign row_last = (row == RW'(PH - 1));
  assign last     = col_last && row_last;

  assign border = BORDER_EN &&
                  ((row == '0) || row_last ||
                   (col == '0) || col_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (adv) begin
      if (last) begin
        row <= '0;
        col <= '0;
      end else if (col_last) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/featuremap_pad_writer.sv
// Zero-border inserter feeding one conv2D channel FIFO.
// Border is only inserted when FEATUREMAP_PAD_BORDER_EN is defined.
module featuremap_pad_writer
  import featuremap_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 56,
  parameter int HEIGHT     = 56
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  featuremap_pad_writer_if.slave  bus,
  output logic                    busy,
  output logic                    frame_done
);
  state_t state;
  state_t state_nx;

  logic                  run;
  logic                  clr;
  logic                  border;
  logic                  last;
  logic                  emit;
  logic                  ready;
  logic                  wrreq_q;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] data_q;

  pad_raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .adv    (emit),
    .border (border),
    .last   (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (emit && last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    run        = (state == RUN);
    clr        = (state != RUN);
    busy       = (state != IDLE);
    frame_done = (state == DONE);
    // fifo_full is almost-full, so one registered write may still land
    ready      = run && !border && !bus.fifo_full;
    emit       = run && !bus.fifo_full &&
                 (border || bus.valid_in);
    word       = border ? '0 : bus.data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrreq_q <= 1'b0;
      data_q  <= '0;
    end else begin
      wrreq_q <= emit;
      if (emit) data_q <= word;
    end
  end

  assign bus.ready_out = ready;
  assign bus.wrreq     = wrreq_q;
  assign bus.data_out  = data_q;

endmodule
